quadrature_encoder_ctrl: RTL

Avalon-MM controlled quadrature encoder controller for the Qsys system. Synchronises raw A/B/Z sensor pins, performs 4x quadrature decoding into a signed 32-bit position counter, and handles index (Z) capture/homing, direction, and decode-error detection. An optional periodic velocity sampler is included. All state runs in the bus clock domain, so the CPU reads coherent values.

---
 rtl/qenc_pkg.sv | 41 ++++
 rtl/quadrature_encoder_ctrl_if.sv | 15 +
 rtl/qenc_decoder.sv | 55 +++++
 rtl/quadrature_encoder_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/qenc_pkg.sv
// Shared constants for the quadrature encoder controller: register map,
// CTRL/STATUS bit positions, default ID word and the decoder step encoding.
package qenc_pkg;

    localparam logic [2:0] ADDR_ID   = 3'd0;
    localparam logic [2:0] ADDR_CTRL = 3'd1;
    localparam logic [2:0] ADDR_POS  = 3'd2;
    localparam logic [2:0] ADDR_IDX  = 3'd3;
    localparam logic [2:0] ADDR_STAT = 3'd4;
    localparam logic [2:0] ADDR_VEL  = 3'd5;
    localparam logic [2:0] ADDR_VPER = 3'd6;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_ZCLR   = 1;
    localparam int CTRL_INVERT = 2;

    localparam int STAT_DIR  = 0;
    localparam int STAT_IDX  = 1;
    localparam int STAT_QERR = 2;

    localparam logic [31:0] ID_WORD_DEF = 32'hEA680004;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ERR  = 2'd3
    } step_t;

    // Byte-lane merge for bus writes.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/quadrature_encoder_ctrl_if.sv
// Avalon-MM control port of the quadrature encoder controller.
interface quadrature_encoder_ctrl_if;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, writedata, byteenable, write, read,
                    input  readdata, waitrequest);
    modport slave  (input  address, writedata, byteenable, write, read,
                    output readdata, waitrequest);
endinterface

// File: rtl/qenc_decoder.sv
// Pin synchronisers, one-sample history and 4x quadrature step decode.
// step/z_rise are combinational from the last sync stage versus history.
module qenc_decoder
    import qenc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  a,
    input  logic  b,
    input  logic  z,
    output step_t step,
    output logic  z_rise
);
    // Each stage holds {A, B, Z}.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  hist_q, hist_d;
    logic [2:0]                  cur;
    logic [1:0]                  ph_cur, ph_prev, ph_diff;

    assign cur = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {a, b, z}};
        hist_d = cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Gray {A,B} -> binary phase, so a forward step is a +1 phase difference.
    assign ph_cur  = {cur[2],    cur[2]    ^ cur[1]};
    assign ph_prev = {hist_q[2], hist_q[2] ^ hist_q[1]};
    assign ph_diff = ph_cur - ph_prev;

    always_comb begin
        case (ph_diff)
            2'd1:    step = STEP_UP;
            2'd3:    step = STEP_DOWN;
            2'd2:    step = STEP_ERR;
            default: step = STEP_NONE;
        endcase
    end

    assign z_rise = cur[0] & ~hist_q[0];

endmodule

// File: rtl/quadrature_encoder_ctrl.sv
// Avalon-MM quadrature encoder controller: register file, position/index
// logic and, with QENC_VELOCITY_EN defined, the periodic velocity sampler.
module quadrature_encoder_ctrl
    import qenc_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [31:0] VEL_PERIOD_RST = 32'd50000,
    parameter logic [31:0] ID_WORD        = ID_WORD_DEF
) (
    input  logic                     csi_MCLK_clk,
    input  logic                     rsi_MRST_reset,
    quadrature_encoder_ctrl_if.slave avs_ctrl,
    input  logic                     A,
    input  logic                     B,
    input  logic                     Z
);
    step_t step;
    logic  z_rise;

    qenc_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
        .clk(csi_MCLK_clk), .rst(rsi_MRST_reset),
        .a(A), .b(B), .z(Z), .step(step), .z_rise(z_rise)
    );

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] pos_q, pos_d, idx_q, idx_d, rdata_q, rdata_d, rd_mux;
    logic        dir_q, dir_d, seen_q, seen_d, qerr_q, qerr_d;
    logic        wr_ctrl, wr_pos, wr_stat, step_en, step_up;

    assign wr_ctrl = avs_ctrl.write && (avs_ctrl.address == ADDR_CTRL);
    assign wr_pos  = avs_ctrl.write && (avs_ctrl.address == ADDR_POS);
    assign wr_stat = avs_ctrl.write && (avs_ctrl.address == ADDR_STAT);
    assign step_en = ctrl_q[CTRL_ENABLE] && (step == STEP_UP || step == STEP_DOWN);
    assign step_up = (step == STEP_UP) ^ ctrl_q[CTRL_INVERT];

    always_comb begin
        ctrl_d = ctrl_q;
        pos_d  = pos_q;
        idx_d  = idx_q;
        dir_d  = dir_q;
        seen_d = seen_q;
        qerr_d = qerr_q;
        if (wr_ctrl && avs_ctrl.byteenable[0]) ctrl_d = avs_ctrl.writedata[2:0];
        // Clears first so a coincident set event overrides them.
        if (wr_stat && avs_ctrl.byteenable[0]) begin
            if (avs_ctrl.writedata[STAT_IDX])  seen_d = 1'b0;
            if (avs_ctrl.writedata[STAT_QERR]) qerr_d = 1'b0;
        end
        if (ctrl_q[CTRL_ENABLE] && step == STEP_ERR) qerr_d = 1'b1;
        if (z_rise) begin
            idx_d  = pos_q;
            seen_d = 1'b1;
        end
        if (wr_pos)
            pos_d = be_merge(pos_q, avs_ctrl.writedata, avs_ctrl.byteenable);
        else if (z_rise && ctrl_q[CTRL_ZCLR])
            pos_d = '0;
        else if (step_en) begin
            pos_d = step_up ? pos_q + 32'd1 : pos_q - 32'd1;
            dir_d = step_up;
        end
    end

`ifdef QENC_VELOCITY_EN
    logic [31:0] vper_q, vper_d, wcnt_q, wcnt_d, snap_q, snap_d, vel_q, vel_d;
    logic        wr_vper;

    assign wr_vper = avs_ctrl.write && (avs_ctrl.address == ADDR_VPER);

    always_comb begin
        vper_d = vper_q;
        wcnt_d = wcnt_q;
        snap_d = snap_q;
        vel_d  = vel_q;
        if (vper_q != '0) begin
            if (wcnt_q == vper_q - 32'd1) begin
                vel_d  = pos_q - snap_q;
                snap_d = pos_q;
                wcnt_d = '0;
            end else begin
                wcnt_d = wcnt_q + 32'd1;
            end
        end
        if (wr_vper) begin
            vper_d = be_merge(vper_q, avs_ctrl.writedata, avs_ctrl.byteenable);
            wcnt_d = '0;
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            vper_q <= VEL_PERIOD_RST;
            wcnt_q <= '0;
            snap_q <= '0;
            vel_q  <= '0;
        end else begin
            vper_q <= vper_d;
            wcnt_q <= wcnt_d;
            snap_q <= snap_d;
            vel_q  <= vel_d;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_ctrl.address)
            ADDR_ID:   rd_mux = ID_WORD;
            ADDR_CTRL: rd_mux = {29'd0, ctrl_q};
            ADDR_POS:  rd_mux = pos_q;
            ADDR_IDX:  rd_mux = idx_q;
            ADDR_STAT: rd_mux = {29'd0, qerr_q, seen_q, dir_q};
`ifdef QENC_VELOCITY_EN
            ADDR_VEL:  rd_mux = vel_q;
            ADDR_VPER: rd_mux = vper_q;
`endif
            default:   rd_mux = '0;
        endcase
        rdata_d = avs_ctrl.read ? rd_mux : rdata_q;
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            ctrl_q  <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            seen_q  <= 1'b0;
            qerr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            seen_q  <= seen_d;
            qerr_q  <= qerr_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_ctrl.readdata    = rdata_q;
    assign avs_ctrl.waitrequest = 1'b0;

endmodule
